// File: rtl/sdram_pkg.sv
// sdram_pkg
// Shared types and default widths for the SDRAM host-port arbiter.
//   HADDR_WIDTH / DATA_WIDTH : default host address and data widths
//   arb_state_t              : arbiter FSM states
//   sdram_cmd_t              : one latched host command (direction, address,
//                              write data and the port that owns it)
package sdram_pkg;

  localparam int HADDR_WIDTH = 22;  // bank(2) + row(12) + col(8)
  localparam int DATA_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                   we;
    logic [HADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]  wdata;
    logic                   owner;
  } sdram_cmd_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
// Combinational two-way round-robin pick.
//   req[1:0] : pending requests, bit N = port N
//   last     : index of the most recently granted port
//   grant    : index of the chosen port (meaningful only when valid)
//   valid    : at least one request is pending
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic       grant,
  output logic       valid
);

  always_comb begin
    valid = |req;
    grant = 1'b0;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      // On a tie the port that did not win last time goes next.
      2'b11:   grant = ~last;
      default: grant = 1'b0;
    endcase
  end

endmodule

// File: rtl/sdram_host_arbiter.sv
// sdram_host_arbiter
// Shares the SDRAM controller host port between two requesters. One command
// is in flight at a time: it is granted round-robin in IDLE, strobed for a
// single ISSUE cycle, and tracked in WAIT until read data returns, the
// controller finishes a write, or the wait counter expires.
// Ports:
//   clk, rst_n                       : clock, async active-low reset
//   pN_req/we/addr/wdata (N = 0, 1)  : requester command, held until pN_ack
//   pN_ack                           : one-cycle pulse when the command issues
//   pN_rvalid / pN_rdata             : read data return for port N
//   sd_wr_addr/sd_wr_data/sd_wr_enable, sd_rd_addr/sd_rd_enable
//                                    : controller command side
//   sd_rd_data, sd_rd_ready, sd_busy : controller response side
//   arb_busy                         : a command is in ISSUE or WAIT
//   timeout_err                      : sticky, a command was abandoned
// The command register uses the package struct, so HADDR_WIDTH and
// DATA_WIDTH must match the sdram_pkg values.
module sdram_host_arbiter #(
  parameter int HADDR_WIDTH = sdram_pkg::HADDR_WIDTH,
  parameter int DATA_WIDTH  = sdram_pkg::DATA_WIDTH,
  parameter int TIMEOUT     = 1023
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   p0_req,
  input  logic                   p0_we,
  input  logic [HADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0]  p0_wdata,
  output logic                   p0_ack,
  output logic                   p0_rvalid,
  output logic [DATA_WIDTH-1:0]  p0_rdata,
  input  logic                   p1_req,
  input  logic                   p1_we,
  input  logic [HADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0]  p1_wdata,
  output logic                   p1_ack,
  output logic                   p1_rvalid,
  output logic [DATA_WIDTH-1:0]  p1_rdata,
  output logic [HADDR_WIDTH-1:0] sd_wr_addr,
  output logic [HADDR_WIDTH-1:0] sd_rd_addr,
  output logic [DATA_WIDTH-1:0]  sd_wr_data,
  output logic                   sd_wr_enable,
  output logic                   sd_rd_enable,
  input  logic [DATA_WIDTH-1:0]  sd_rd_data,
  input  logic                   sd_rd_ready,
  input  logic                   sd_busy,
  output logic                   arb_busy,
  output logic                   timeout_err
);

  import sdram_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The abort is decided in the cycle whose increment brings the counter to
  // TIMEOUT, so WAIT lasts at most TIMEOUT cycles.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

  arb_state_t       state_q, state_d;
  sdram_cmd_t       cmd_q;
  logic             last_q;
  logic             seen_busy_q;
  logic [CNT_W-1:0] wait_cnt_q;
  logic             timeout_err_q;
  logic [1:0]       rvalid_q;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata1_q;

  logic pick_grant, pick_valid;
  logic grab, rd_done, wr_done, expire;
  logic issuing;

  rr_arb2 u_rr (
    .req   ({p1_req, p0_req}),
    .last  (last_q),
    .grant (pick_grant),
    .valid (pick_valid)
  );

  // Next state and completion events. A write only completes on sd_busy low
  // after the controller has been seen busy, so a controller that has not yet
  // reacted in the first WAIT cycle is not mistaken for a finished write.
  always_comb begin
    state_d = state_q;
    grab    = 1'b0;
    rd_done = 1'b0;
    wr_done = 1'b0;
    expire  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!sd_busy && pick_valid) begin
          grab    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (!cmd_q.we && sd_rd_ready) begin
          rd_done = 1'b1;
        end else if (cmd_q.we && seen_busy_q && !sd_busy) begin
          wr_done = 1'b1;
        end else if (wait_cnt_q >= CNT_LAST) begin
          expire = 1'b1;
        end
        if (rd_done || wr_done || expire) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cmd_q         <= '0;
      last_q        <= 1'b1;
      seen_busy_q   <= 1'b0;
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
      rvalid_q      <= 2'b00;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
    end else begin
      state_q  <= state_d;
      rvalid_q <= 2'b00;
      if (grab) begin
        cmd_q.we    <= pick_grant ? p1_we    : p0_we;
        cmd_q.addr  <= pick_grant ? p1_addr  : p0_addr;
        cmd_q.wdata <= pick_grant ? p1_wdata : p0_wdata;
        cmd_q.owner <= pick_grant;
        last_q      <= pick_grant;
      end
      if (state_q == ISSUE) begin
        seen_busy_q <= 1'b0;
        wait_cnt_q  <= '0;
      end else if (state_q == WAIT) begin
        if (sd_busy) begin
          seen_busy_q <= 1'b1;
        end
        if (wait_cnt_q != CNT_MAX) begin
          wait_cnt_q <= wait_cnt_q + 1'b1;
        end
      end
      if (expire) begin
        timeout_err_q <= 1'b1;
      end
      if (rd_done) begin
        rvalid_q[cmd_q.owner] <= 1'b1;
        if (cmd_q.owner) begin
          rdata1_q <= sd_rd_data;
        end else begin
          rdata0_q <= sd_rd_data;
        end
      end
    end
  end

  // Strobes and acks decode the state register directly so an async reset
  // removes them at once. Addresses follow the held command register.
  assign issuing      = (state_q == ISSUE);
  assign sd_rd_enable = issuing & ~cmd_q.we;
  assign sd_wr_enable = issuing &  cmd_q.we;
  assign p0_ack       = issuing & ~cmd_q.owner;
  assign p1_ack       = issuing &  cmd_q.owner;
  assign sd_rd_addr   = cmd_q.we ? '0 : cmd_q.addr;
  assign sd_wr_addr   = cmd_q.we ? cmd_q.addr  : '0;
  assign sd_wr_data   = cmd_q.we ? cmd_q.wdata : '0;
  assign p0_rvalid    = rvalid_q[0];
  assign p1_rvalid    = rvalid_q[1];
  assign p0_rdata     = rdata0_q;
  assign p1_rdata     = rdata1_q;
  assign arb_busy     = (state_q != IDLE);
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_sdram_host_arbiter.sv
// tb_sdram_host_arbiter
// Self-checking bench for sdram_host_arbiter. The bench plays both requesters
// and the SDRAM controller, and predicts each command at transaction level:
// winner from the round-robin rule, ack one cycle after the IDLE sample,
// completion cycle from the controller response it chooses, sticky error and
// per-port last read data.
module tb_sdram_host_arbiter;

  localparam int AW  = 22;
  localparam int DW  = 16;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_ack, p0_rvalid, p1_ack, p1_rvalid;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic [AW-1:0] sd_wr_addr, sd_rd_addr;
  logic [DW-1:0] sd_wr_data;
  logic          sd_wr_enable, sd_rd_enable;
  logic [DW-1:0] sd_rd_data = '0;
  logic          sd_rd_ready = 1'b0;
  logic          sd_busy = 1'b0;
  logic          arb_busy, timeout_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int            last_g = 1;
  logic          err_m = 1'b0;
  logic [DW-1:0] rdata_m [2];

  sdram_host_arbiter #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .sd_wr_addr(sd_wr_addr), .sd_rd_addr(sd_rd_addr), .sd_wr_data(sd_wr_data),
    .sd_wr_enable(sd_wr_enable), .sd_rd_enable(sd_rd_enable),
    .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy),
    .arb_busy(arb_busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic ackOf(input int p);
    return (p == 0) ? p0_ack : p1_ack;
  endfunction

  function automatic logic rvalidOf(input int p);
    return (p == 0) ? p0_rvalid : p1_rvalid;
  endfunction

  function automatic logic [DW-1:0] rdataOf(input int p);
    return (p == 0) ? p0_rdata : p1_rdata;
  endfunction

  task automatic setReq(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = a; p0_wdata = d;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic dropReq(input int p);
    if (p == 0) p0_req = 1'b0;
    else        p1_req = 1'b0;
  endtask

  task automatic resetModel();
    last_g     = 1;
    err_m      = 1'b0;
    rdata_m[0] = '0;
    rdata_m[1] = '0;
  endtask

  task automatic checkResetState();
    checkOutput("rst_ctrl", 32'({p0_ack, p1_ack, p0_rvalid, p1_rvalid, sd_wr_enable,
                                 sd_rd_enable, arb_busy, timeout_err}), 0);
    checkOutput("rst_rd_addr", 32'(sd_rd_addr), 0);
    checkOutput("rst_wr_addr", 32'(sd_wr_addr), 0);
    checkOutput("rst_wr_data", 32'(sd_wr_data), 0);
    checkOutput("rst_rdata", {p0_rdata, p1_rdata}, 0);
  endtask

  // Runs one command from an IDLE negedge with requests already presented.
  // lat: extra WAIT cycles before read data; busy_hi: controller busy cycles
  // for a write; expire: a read that never gets data.
  task automatic runCommand(input int lat, input int busy_hi, input bit expire, input logic [DW-1:0] rdv);
    int w, o;
    logic we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    if (p0_req && p1_req) w = 1 - last_g;
    else if (p0_req)      w = 0;
    else                  w = 1;
    o  = 1 - w;
    we = (w == 0) ? p0_we : p1_we;
    a  = (w == 0) ? p0_addr : p1_addr;
    wd = (w == 0) ? p0_wdata : p1_wdata;
    last_g = w;

    tick();
    checkOutput("ack_owner", 32'(ackOf(w)), 1);
    checkOutput("ack_other", 32'(ackOf(o)), 0);
    checkOutput("strobes", 32'({sd_wr_enable, sd_rd_enable}), we ? 2 : 1);
    if (we) begin
      checkOutput("wr_addr", 32'(sd_wr_addr), 32'(a));
      checkOutput("wr_data", 32'(sd_wr_data), 32'(wd));
    end else begin
      checkOutput("rd_addr", 32'(sd_rd_addr), 32'(a));
    end
    dropReq(w);

    tick();
    checkOutput("wait_quiet", 32'({sd_wr_enable, sd_rd_enable, p0_ack, p1_ack}), 0);
    if (we) begin
      sd_busy     = 1'b0;
      sd_rd_ready = 1'($urandom_range(0, 1));
      tick();
      for (int i = 0; i < busy_hi; i++) begin
        checkOutput("wr_hold", 32'(arb_busy), 1);
        sd_busy     = 1'b1;
        sd_rd_ready = 1'($urandom_range(0, 1));
        tick();
      end
      checkOutput("wr_hold", 32'(arb_busy), 1);
      sd_busy     = 1'b0;
      sd_rd_ready = 1'b0;
      tick();
    end else if (expire) begin
      for (int i = 1; i <= TMO; i++) begin
        checkOutput("tmo_wait", 32'({arb_busy, timeout_err, p0_rvalid, p1_rvalid}), {28'd0, 1'b1, err_m, 2'b00});
        sd_busy = (i < TMO) ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      err_m = 1'b1;
    end else begin
      for (int i = 0; i < lat; i++) begin
        checkOutput("rd_hold", 32'({arb_busy, p0_rvalid, p1_rvalid}), 4);
        sd_busy = 1'($urandom_range(0, 1));
        tick();
      end
      sd_busy     = 1'b0;
      sd_rd_ready = 1'b1;
      sd_rd_data  = rdv;
      tick();
      sd_rd_ready = 1'b0;
      sd_rd_data  = 16'($urandom);
      rdata_m[w]  = rdv;
    end

    checkOutput("done_idle", 32'(arb_busy), 0);
    checkOutput("rvalid_owner", 32'(rvalidOf(w)), (!we && !expire) ? 1 : 0);
    checkOutput("rvalid_other", 32'(rvalidOf(o)), 0);
    checkOutput("rdata_owner", 32'(rdataOf(w)), 32'(rdata_m[w]));
    checkOutput("rdata_other", 32'(rdataOf(o)), 32'(rdata_m[o]));
    checkOutput("timeout_err", 32'(timeout_err), 32'(err_m));
  endtask

  // Presents random new requests and optionally holds the controller busy
  // (with stray read-ready pulses) for a few IDLE cycles first.
  task automatic applyStimulus();
    for (int p = 0; p < 2; p++) begin
      if (!((p == 0) ? p0_req : p1_req) && ($urandom_range(0, 1) == 1))
        setReq(p, 1'($urandom_range(0, 1)), 22'($urandom), 16'($urandom));
    end
    if (!p0_req && !p1_req)
      setReq(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 22'($urandom), 16'($urandom));
    if ($urandom_range(0, 3) == 0) begin
      int n;
      n = int'($urandom_range(1, 3));
      for (int i = 0; i < n; i++) begin
        sd_busy     = 1'b1;
        sd_rd_ready = 1'($urandom_range(0, 1));
        tick();
        checkOutput("blocked", 32'({p0_ack, p1_ack, arb_busy, p0_rvalid, p1_rvalid}), 0);
      end
      sd_busy     = 1'b0;
      sd_rd_ready = 1'b0;
    end
  endtask

  initial begin
    resetModel();
    #1 rst_n = 1'b0;
    @(negedge clk);
    checkResetState();
    rst_n = 1'b1;
    tick();

    $display("[TB] single read");
    setReq(0, 1'b0, 22'h012345, 16'h0000);
    runCommand(1, 0, 1'b0, 16'hBEEF);
    tick();
    checkOutput("rvalid_pulse", 32'({p0_rvalid, p1_rvalid}), 0);

    $display("[TB] write completion");
    setReq(1, 1'b1, 22'h3FFFFF, 16'hA5A5);
    runCommand(0, 5, 1'b0, 16'h0000);

    $display("[TB] tie alternation");
    for (int k = 0; k < 4; k++) begin
      if (!p0_req) setReq(0, 1'b0, 22'($urandom), 16'($urandom));
      if (!p1_req) setReq(1, 1'b1, 22'($urandom), 16'($urandom));
      runCommand(1, 2, 1'b0, 16'($urandom));
    end
    runCommand(0, 1, 1'b0, 16'($urandom));

    $display("[TB] timeout");
    setReq(0, 1'b0, 22'h000ABC, 16'h0000);
    runCommand(0, 0, 1'b1, 16'h0000);
    setReq(1, 1'b0, 22'h001234, 16'h0000);
    runCommand(2, 0, 1'b0, 16'h5A5A);

    $display("[TB] reset mid-WAIT");
    setReq(0, 1'b0, 22'h00F00D, 16'h0000);
    tick();
    dropReq(0);
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1 checkResetState();
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    sd_rd_ready = 1'b1;
    sd_rd_data  = 16'h1234;
    tick();
    sd_rd_ready = 1'b0;
    checkOutput("late_ready", 32'({p0_rvalid, p1_rvalid, arb_busy}), 0);
    setReq(0, 1'b0, 22'h00F00D, 16'h0000);
    setReq(1, 1'b1, 22'h000042, 16'h7777);
    runCommand(0, 1, 1'b0, 16'hC0DE);

    $display("[TB] reset in ISSUE");
    tick();
    checkOutput("issue_pre", 32'({sd_wr_enable, p1_ack}), 3);
    #2 rst_n = 1'b0;
    #1 checkResetState();
    dropReq(1);
    @(negedge clk);
    rst_n = 1'b1;
    resetModel();
    tick();

    $display("[TB] random traffic");
    for (int t = 0; t < 40; t++) begin
      applyStimulus();
      runCommand(int'($urandom_range(0, 6)), int'($urandom_range(1, 5)),
                 ($urandom_range(0, 7) == 0), 16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sdram_host_arbiter.md
# sdram_host_arbiter

Two-requester arbiter that shares the single host port of the SDRAM controller between port 0 and port 1. Grants one read or write command at a time with round-robin fairness and tracks it to completion. Routes read data back to the owning requester. Flags commands that never complete. Sits between the client masters and the SDRAM controller host interface, in the same clock domain.

## Interface
- HADDR_WIDTH, 22, host address width (bank + row + col = 2 + 12 + 8)
- DATA_WIDTH, 16, host data width
- TIMEOUT, 1023, maximum cycles in WAIT before abort
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- pN_req  in  1  port N (N = 0, 1) command request; held until pN_ack
- pN_we  in  1  port N: 1 = write, 0 = read; stable while req
- pN_addr  in  HADDR_WIDTH  port N address; stable while req
- pN_wdata  in  DATA_WIDTH  port N write data; stable while req
- pN_ack  out  1  one-cycle pulse when port N's command is issued
- pN_rvalid  out  1  one-cycle pulse, port N read data valid
- pN_rdata  out  DATA_WIDTH  port N read data, valid with pN_rvalid
- sd_wr_addr, sd_rd_addr  out  HADDR_WIDTH  controller write/read address
- sd_wr_data  out  DATA_WIDTH  controller write data
- sd_wr_enable, sd_rd_enable  out  1  controller command strobes
- sd_rd_data  in  DATA_WIDTH  controller read data
- sd_rd_ready  in  1  controller read-data-valid pulse
- sd_busy  in  1  controller busy
- arb_busy  out  1  high whenever state != IDLE
- timeout_err  out  1  sticky; set on timeout abort, cleared only by reset

## Operation
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If sd_busy = 0 and any request is pending, latch the winner's we, addr and wdata into command registers, record owner, update the round-robin pointer and go to ISSUE.
  - Otherwise stay in IDLE.
- Round robin:
  - A single requester always wins.
  - When both request, grant the port other than the last granted port.
  - The last-grant pointer resets to 1, so port 0 wins the first tie.
- ISSUE (exactly 1 cycle):
  - Assert sd_rd_enable or sd_wr_enable per the latched we.
  - Drive the latched address on the matching sd_*_addr.
  - Drive sd_wr_data for writes.
  - Pulse owner's pN_ack.
  - Then go to WAIT.
- WAIT: complete on the first of these events, then return to IDLE.
  - Read: sd_rd_ready = 1. Capture sd_rd_data, and next cycle pulse owner's pN_rvalid with pN_rdata = captured value.
  - Write: sd_busy = 0 after sd_busy has been sampled high (seen_busy flag, cleared on ISSUE). sd_busy low in the first WAIT cycle does not complete a write.
  - Timeout: wait counter reaches TIMEOUT. Set timeout_err; no rvalid is produced.
- Command registers hold their value after ISSUE; strobes are high only in ISSUE.
- pN_rdata holds its last value between pulses.

## Timing
- Reset values: all outputs 0 (strobes, acks, rvalids, addresses, data, arb_busy, timeout_err); state IDLE; counter 0.
- Request latency: pN_req sampled in IDLE at cycle T gives ISSUE / pN_ack / strobe at T+1, and WAIT from T+2.
- Read return: sd_rd_ready at cycle R gives pN_rvalid at R+1, and IDLE at R+1.
- Back-to-back: the next grant is evaluated in the IDLE cycle after completion. Minimum spacing between strobes is 3 cycles plus controller latency.
- A request arriving during ISSUE or WAIT waits. A request arriving in the same cycle as completion is first considered in the following IDLE cycle.
- Requester dropping pN_req before ack is a protocol violation. Behaviour is undefined only for that port; the other port is unaffected.
- sd_rd_ready in IDLE, in ISSUE, or during a write is ignored.
- Asynchronous reset mid-operation:
  - Strobes and acks drop immediately and state goes to IDLE.
  - The in-flight command is abandoned and produces no pN_rvalid.
  - The requester must re-request.
- Wait counter: log2(TIMEOUT+1) bits; cleared on entering WAIT; saturates and never wraps.

## Structure
- Package sdram_pkg:
  - HADDR_WIDTH and DATA_WIDTH defaults
  - arb_state_t enum {IDLE, ISSUE, WAIT}
  - command struct {we, addr, wdata, owner}
- Sub-module rr_arb2: combinational two-way round-robin pick from req[1:0] and last pointer. Outputs grant index and valid.

## Test plan
- Single read: p0 read addr 0x012345. Expect p0_ack at T+1 and sd_rd_enable for 1 cycle with sd_rd_addr 0x012345. Model returns 0xBEEF with sd_rd_ready; expect p0_rvalid next cycle with p0_rdata 0xBEEF, and p1 outputs quiet.
- Tie then alternation: p0 and p1 both hold req for 4 commands. Expect grants in order p0, p1, p0, p1.
- Write completion: p1 write 0x3FFFFF with 0xA5A5. The model holds sd_busy low in the first WAIT cycle and then high for 5 cycles. Expect no early IDLE, and arb_busy falling the cycle after sd_busy falls.
- Timeout: TIMEOUT = 8; read with sd_rd_ready never asserted. Expect timeout_err at WAIT cycle 8, return to IDLE, no p0_rvalid, and the next request still serviced.
- Reset mid-WAIT: assert rst_n low during a read. Expect all outputs 0 immediately. A late sd_rd_ready after reset produces no rvalid.
